sdf_twiddle_gen: RTL and testbench
==================================

Name: sdf_twiddle_gen

Overview:
Parametrised, registered twiddle-factor generator for one radix-2 DIF single-path-delay-feedback (SDF) FFT stage. It replaces per-stage hand-written constant ROMs.
- Holds an elaboration-computed quarter-wave cosine table.
- Tracks sample position inside the stage's butterfly segment with an internal counter.
- Emits the complex twiddle W_N^(j·2^s), aligned one cycle after each accepted sample, ready for the stage's complex multiplier.

Parameters:
- LOG2N, 5: log2 of FFT size N. Legal range 3..12.
- STAGE_IDX, 0: stage s, 0..LOG2N-1. Segment length L = N>>s, half H = L/2.
- DATA_W, 22: two's-complement output width.
- FRAC_W, 6: fractional bits of output. Must satisfy FRAC_W+2 <= DATA_W.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: one stage sample accepted this cycle.
- frame_start, input, 1: marks the first sample of a frame. Honoured only with in_valid.
- tw_valid, output, 1: twiddle outputs are valid.
- tw_re, output, DATA_W: twiddle real part, Q(DATA_W-FRAC_W).FRAC_W.
- tw_im, output, DATA_W: twiddle imaginary part, same format.
- tw_bypass, output, 1: twiddle is exactly 1+j0 (first half of segment); the multiplier may be skipped.
- seg_last, output, 1: the emitted twiddle belongs to the last sample of the segment.
- inverse, input, 1: present only with TWIDDLE_CONJ_EN; high selects the IFFT twiddle.

Behaviour:
- Reset (async assert, sync release): all of the following are 0 — cnt, tw_valid, tw_re, tw_im, tw_bypass, seg_last.
- Table: T[k] = round(cos(2πk/N)·2^FRAC_W), k = 0..N/4, round half away from zero. Computed at elaboration; no runtime trig.
- Counter cnt, width log2(L), advances only on in_valid.
  - Effective index: idx = 0 if frame_start, else cnt.
  - On in_valid: cnt <= (idx == L-1) ? 0 : idx+1. Wrap-around is natural; no error on partial frames.
  - frame_start without in_valid is ignored.
- Twiddle for idx:
  - If idx < H: re = 2^FRAC_W, im = 0, bypass = 1.
  - Otherwise: j = idx-H, e = j<<s (e < N/2), bypass = 0.
    - If e <= N/4: re = T[e], else re = -T[N/2-e].
    - im = -T[|N/4-e|].
  - Results are sign-extended to DATA_W.
- Last stage (L = 2): every twiddle is 1+j0; bypass is 1 only for idx 0 (formula above).
- Latency: exactly 1 cycle. The registered tw_* outputs correspond to the in_valid of the previous cycle.
  - tw_valid = in_valid delayed by one cycle.
  - seg_last = (idx == L-1) registered.
- Stall: when in_valid is low, tw_valid <= 0; tw_re, tw_im and tw_bypass hold their values; cnt holds.
- Reset mid-frame: counter and outputs clear immediately. The next accepted sample is treated as idx 0 even without frame_start.
- Elaboration check: illegal parameter combinations raise a fatal message.

Optional Feature:
TWIDDLE_CONJ_EN
- Defined: the inverse port exists. When inverse = 1 the im result is negated before registering, giving W^-e for IFFT; re is unchanged. inverse is sampled together with in_valid.
- Undefined: the port is absent and only the forward twiddle is produced.

Decomposition:
- Package fft_pkg holds:
  - twiddle_t: struct {logic signed [DATA_W-1:0] re, im}.
  - Default LOG2N, DATA_W and FRAC_W constants.
  - Constant function cos_q(k, n, frac) used to build the table.
- One sub-module, twiddle_qrom: combinational quarter-wave table lookup, k -> T[k], depth N/4+1. The parent does the symmetry folding, counter and registers.

Test Plan:
All values at LOG2N=5, STAGE_IDX=1, DATA_W=22, FRAC_W=6 (L=16, H=8).
1. Reset, then frame_start + 16 consecutive in_valid → first 8 outputs: tw_re=22'h000040, tw_im=0, tw_bypass=1, tw_valid=1 starting one cycle after the first in_valid.
2. Same frame, idx 9 (e=2) → tw_re=22'h00003B (59), tw_im=22'h3FFFE8 (-24). Idx 12 (e=8) → re=0, im=22'h3FFFC0 (-64).
3. Idx 14 (e=12) → re=im=22'h3FFFD3 (-45). Idx 15 → seg_last=1; the next in_valid wraps to idx 0 (bypass=1).
4. in_valid deasserted for 3 cycles mid-segment → tw_valid=0, tw_* held. Resume continues at the next idx with no skipped twiddles.
5. frame_start asserted at cnt=5 → that sample emits idx 0 (1+j0); the following sample is idx 1. rst_n pulsed mid-frame → outputs 0 asynchronously, restart at idx 0.
6. TWIDDLE_CONJ_EN defined, inverse=1, idx 9 → tw_re=59, tw_im=22'h000018 (+24). Repeat with STAGE_IDX=4 → all twiddles 1+j0.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared types, default sizes and the elaboration-time cosine
//             helper used by the SDF FFT twiddle generator.
//  Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int c_DEF_LOG2N  = 5;
    localparam int c_DEF_DATA_W = 22;
    localparam int c_DEF_FRAC_W = 6;

    // Complex twiddle at the default output width.
    typedef struct packed {
        logic signed [c_DEF_DATA_W-1:0] re;
        logic signed [c_DEF_DATA_W-1:0] im;
    } twiddle_t;

    // round(cos(2*pi*k/n) * 2^frac) for 0 <= k <= n/4, evaluated only while
    // elaborating. A Taylor series keeps this free of math-library calls; the
    // argument never exceeds pi/2, so 12 terms are far beyond the precision needed.
    // The quarter-wave cosine is non-negative, so +0.5 then truncate is
    // round-half-away-from-zero (the tiny negative residue at k=n/4 lands on 0).
    function automatic int cos_q(input int k, input int n, input int frac);
        real x;
        real x2;
        real term;
        real sum;
        real scaled;
        x    = 2.0 * 3.14159265358979323846 * k / n;
        x2   = x * x;
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i <= 12; i++) begin
            term = -term * x2 / ((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        scaled = sum * (1 << frac);
        return $rtoi(scaled + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_qrom.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_qrom
//  Purpose  : Combinational quarter-wave cosine table, k -> T[k],
//             depth N/4+1, values unsigned 0..2^FRAC_W.
//  Revision : 1.0 - initial release
// ============================================================================
module twiddle_qrom
    import fft_pkg::*;
#(
    parameter int LOG2N  = c_DEF_LOG2N,
    parameter int FRAC_W = c_DEF_FRAC_W
) (
    input  logic [LOG2N-2:0] k_i,
    output logic [FRAC_W:0]  t_o
);

    localparam int c_N     = 1 << LOG2N;
    localparam int c_DEPTH = c_N / 4 + 1;

    logic [FRAC_W:0] w_tab [c_DEPTH];

    for (genvar k = 0; k < c_DEPTH; k++) begin : g_tab
        localparam int c_T = cos_q(k, c_N, FRAC_W);
        assign w_tab[k] = (FRAC_W + 1)'(c_T);
    end

    // Table lookup; addresses beyond N/4 are never issued by the parent.
    always_comb begin
        t_o = '0;
        if (int'(k_i) < c_DEPTH) begin
            t_o = w_tab[k_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdf_twiddle_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sdf_twiddle_gen
//  Purpose  : Registered twiddle generator for one radix-2 DIF SDF stage.
//             Tracks the sample position in the butterfly segment and emits
//             W_N^(j*2^s) one cycle after each accepted sample.
//  Options  : define TWIDDLE_CONJ_EN to add the 'inverse' port (IFFT twiddles).
//  Revision : 1.0 - initial release
// ============================================================================
module sdf_twiddle_gen
    import fft_pkg::*;
#(
    parameter int LOG2N     = c_DEF_LOG2N,
    parameter int STAGE_IDX = 0,
    parameter int DATA_W    = c_DEF_DATA_W,
    parameter int FRAC_W    = c_DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              frame_start,
`ifdef TWIDDLE_CONJ_EN
    input  logic              inverse,
`endif
    output logic              tw_valid,
    output logic [DATA_W-1:0] tw_re,
    output logic [DATA_W-1:0] tw_im,
    output logic              tw_bypass,
    output logic              seg_last
);

    localparam int c_N     = 1 << LOG2N;
    localparam int c_CNT_W = LOG2N - STAGE_IDX;      // log2 of segment length
    localparam int c_AW    = LOG2N - 1;              // holds any e < N/2
    localparam logic [c_AW-1:0]   c_QTR = c_AW'(c_N / 4);
    localparam logic [DATA_W-1:0] c_ONE = DATA_W'(2 ** FRAC_W);

    if (LOG2N < 3 || LOG2N > 12 || STAGE_IDX < 0 || STAGE_IDX > LOG2N - 1 ||
        FRAC_W < 0 || FRAC_W + 2 > DATA_W) begin : g_param_err
        $fatal(1, "sdf_twiddle_gen: illegal parameters LOG2N=%0d STAGE_IDX=%0d DATA_W=%0d FRAC_W=%0d",
               LOG2N, STAGE_IDX, DATA_W, FRAC_W);
    end

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  re_q, re_d;
    logic [DATA_W-1:0]  im_q, im_d;
    logic               bypass_q, bypass_d;
    logic               seg_last_q, seg_last_d;

    logic [c_CNT_W-1:0] w_idx;
    logic [c_AW-1:0]    w_j;
    logic [c_AW-1:0]    w_e;
    logic               w_e_le_q;
    logic [c_AW-1:0]    w_re_k;
    logic [c_AW-1:0]    w_im_k;
    logic [FRAC_W:0]    w_re_t;
    logic [FRAC_W:0]    w_im_t;
    logic [DATA_W-1:0]  w_re_mag;
    logic [DATA_W-1:0]  w_im_mag;
    logic [DATA_W-1:0]  w_re_fold;
    logic [DATA_W-1:0]  w_im_fold;

    // frame_start forces the current sample to the segment start.
    assign w_idx = frame_start ? '0 : cnt_q;

    // j = idx - H is just the index without its MSB (only meaningful in the upper half).
    if (c_CNT_W >= 2) begin : g_j_wide
        assign w_j = c_AW'(w_idx[c_CNT_W-2:0]);
    end else begin : g_j_last
        assign w_j = '0;
    end

    assign w_e      = w_j << STAGE_IDX;
    assign w_e_le_q = (w_e <= c_QTR);

    // N/2 equals 2^c_AW, so N/2 - e is the c_AW-bit two's complement of e.
    assign w_re_k = w_e_le_q ? w_e : ('0 - w_e);
    assign w_im_k = w_e_le_q ? (c_QTR - w_e) : (w_e - c_QTR);

    twiddle_qrom #(
        .LOG2N  (LOG2N),
        .FRAC_W (FRAC_W)
    ) u_qrom_re (
        .k_i (w_re_k),
        .t_o (w_re_t)
    );

    twiddle_qrom #(
        .LOG2N  (LOG2N),
        .FRAC_W (FRAC_W)
    ) u_qrom_im (
        .k_i (w_im_k),
        .t_o (w_im_t)
    );

    assign w_re_mag  = {{(DATA_W-FRAC_W-1){1'b0}}, w_re_t};
    assign w_im_mag  = {{(DATA_W-FRAC_W-1){1'b0}}, w_im_t};
    assign w_re_fold = w_e_le_q ? w_re_mag : ('0 - w_re_mag);
`ifdef TWIDDLE_CONJ_EN
    // Conjugate twiddle for the inverse transform: imaginary sign flips.
    assign w_im_fold = inverse ? w_im_mag : ('0 - w_im_mag);
`else
    assign w_im_fold = '0 - w_im_mag;
`endif

    // Next state: counter advance and twiddle selection on accepted samples, hold otherwise.
    always_comb begin
        cnt_d      = cnt_q;
        valid_d    = in_valid;
        re_d       = re_q;
        im_d       = im_q;
        bypass_d   = bypass_q;
        seg_last_d = seg_last_q;
        if (in_valid) begin
            cnt_d      = (w_idx == '1) ? '0 : w_idx + c_CNT_W'(1);
            seg_last_d = (w_idx == '1);
            if (!w_idx[c_CNT_W-1]) begin
                re_d     = c_ONE;
                im_d     = '0;
                bypass_d = 1'b1;
            end else begin
                re_d     = w_re_fold;
                im_d     = w_im_fold;
                bypass_d = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            re_q       <= '0;
            im_q       <= '0;
            bypass_q   <= 1'b0;
            seg_last_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            re_q       <= re_d;
            im_q       <= im_d;
            bypass_q   <= bypass_d;
            seg_last_q <= seg_last_d;
        end
    end

    assign tw_valid  = valid_q;
    assign tw_re     = re_q;
    assign tw_im     = im_q;
    assign tw_bypass = bypass_q;
    assign seg_last  = seg_last_q;

endmodule
`default_nettype wire

// File: tb/tb_sdf_twiddle_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdf_twiddle_gen
//  Purpose  : Self-checking bench for sdf_twiddle_gen. Two instances at
//             LOG2N=5: stage 1 (L=16) and stage 4 (L=2), fed the same stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdf_twiddle_gen;

`ifdef TWIDDLE_CONJ_EN
    localparam bit c_CONJ = 1'b1;
`else
    localparam bit c_CONJ = 1'b0;
`endif

    typedef struct {
        logic [21:0] re;
        logic [21:0] im;
        logic        byp;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic frame_start;
    logic inverse;

    logic        tw_valid_a, tw_bypass_a, seg_last_a;
    logic [21:0] tw_re_a, tw_im_a;
    logic        tw_valid_b, tw_bypass_b, seg_last_b;
    logic [21:0] tw_re_b, tw_im_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t hold_a;
    exp_t hold_b;
    int   m_cnt_a;
    int   m_cnt_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sdf_twiddle_gen #(
        .LOG2N(5), .STAGE_IDX(1), .DATA_W(22), .FRAC_W(6)
    ) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .frame_start (frame_start),
`ifdef TWIDDLE_CONJ_EN
        .inverse     (inverse),
`endif
        .tw_valid    (tw_valid_a),
        .tw_re       (tw_re_a),
        .tw_im       (tw_im_a),
        .tw_bypass   (tw_bypass_a),
        .seg_last    (seg_last_a)
    );

    sdf_twiddle_gen #(
        .LOG2N(5), .STAGE_IDX(4), .DATA_W(22), .FRAC_W(6)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .frame_start (frame_start),
`ifdef TWIDDLE_CONJ_EN
        .inverse     (inverse),
`endif
        .tw_valid    (tw_valid_b),
        .tw_re       (tw_re_b),
        .tw_im       (tw_im_b),
        .tw_bypass   (tw_bypass_b),
        .seg_last    (seg_last_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return int'($floor(v + 0.5));
        return -int'($floor(-v + 0.5));
    endfunction

    // Reference: W = exp(-j*2*pi*e/N) scaled by 2^6, computed directly (no folding).
    function automatic exp_t model(input int idx, input int s, input bit inv);
        exp_t r;
        int   n;
        int   l;
        int   e;
        int   re_i;
        int   im_i;
        real  a;
        n = 32;
        l = n >> s;
        if (idx < l / 2) begin
            re_i  = 64;
            im_i  = 0;
            r.byp = 1'b1;
        end else begin
            e    = (idx - l / 2) << s;
            a    = 2.0 * 3.141592653589793 * e / n;
            re_i = rnd($cos(a) * 64.0);
            im_i = rnd(-$sin(a) * 64.0);
            if (inv) im_i = -im_i;
            r.byp = 1'b0;
        end
        r.re   = re_i[21:0];
        r.im   = im_i[21:0];
        r.last = (idx == l - 1);
        return r;
    endfunction

    task automatic clear_model();
        m_cnt_a = 0;
        m_cnt_b = 0;
        hold_a  = '{22'h0, 22'h0, 1'b0, 1'b0};
        hold_b  = '{22'h0, 22'h0, 1'b0, 1'b0};
        q_a.delete();
        q_b.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid_a"}, tw_valid_a, 0);
        check({tag, "_re_a"},    tw_re_a,    0);
        check({tag, "_im_a"},    tw_im_a,    0);
        check({tag, "_byp_a"},   tw_bypass_a, 0);
        check({tag, "_last_a"},  seg_last_a, 0);
        check({tag, "_valid_b"}, tw_valid_b, 0);
        check({tag, "_re_b"},    tw_re_b,    0);
        check({tag, "_byp_b"},   tw_bypass_b, 0);
    endtask

    // One clock: drive at the falling edge, push expectations, compare after the next rising edge.
    task automatic step(input bit v, input bit fs, input bit inv);
        int   ia;
        int   ib;
        exp_t ea;
        exp_t eb;
        in_valid    = v;
        frame_start = fs;
        inverse     = inv;
        if (v) begin
            ia      = fs ? 0 : m_cnt_a;
            m_cnt_a = (ia == 15) ? 0 : ia + 1;
            q_a.push_back(model(ia, 1, inv && c_CONJ));
            ib      = fs ? 0 : m_cnt_b;
            m_cnt_b = (ib == 1) ? 0 : ib + 1;
            q_b.push_back(model(ib, 4, inv && c_CONJ));
        end
        @(posedge clk);
        @(negedge clk);
        check("valid_a", tw_valid_a, v);
        check("valid_b", tw_valid_b, v);
        if (v) begin
            ea     = q_a.pop_front();
            eb     = q_b.pop_front();
            hold_a = ea;
            hold_b = eb;
            check("last_a", seg_last_a, ea.last);
            check("last_b", seg_last_b, eb.last);
        end
        check("re_a",  tw_re_a,     hold_a.re);
        check("im_a",  tw_im_a,     hold_a.im);
        check("byp_a", tw_bypass_a, hold_a.byp);
        check("re_b",  tw_re_b,     hold_b.re);
        check("im_b",  tw_im_b,     hold_b.im);
        check("byp_b", tw_bypass_b, hold_b.byp);
    endtask

    // A full 16-sample segment on stage 1 with the hand-computed reference points.
    task automatic run_frame(input bit inv);
        bit conj;
        conj = inv && c_CONJ;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i == 0, inv);
            if (i < 8) begin
                check("plan_one_re", tw_re_a, 22'h000040);
                check("plan_one_byp", tw_bypass_a, 1);
            end
            if (i == 9) begin
                check("plan_re9", tw_re_a, 22'h00003B);
                check("plan_im9", tw_im_a, conj ? 22'h000018 : 22'h3FFFE8);
            end
            if (i == 12) begin
                check("plan_re12", tw_re_a, 22'h000000);
                check("plan_im12", tw_im_a, conj ? 22'h000040 : 22'h3FFFC0);
            end
            if (i == 14) begin
                check("plan_re14", tw_re_a, 22'h3FFFD3);
                check("plan_im14", tw_im_a, conj ? 22'h00002D : 22'h3FFFD3);
            end
            if (i == 15) check("plan_last15", seg_last_a, 1);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        inverse     = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Full segment, then wrap to idx 0.
        run_frame(1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("wrap_byp", tw_bypass_a, 1);

        // Stall mid-segment, then resume.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);

        // frame_start at cnt 5 restarts the segment.
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("fs_restart_re", tw_re_a, 22'h000040);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);

`ifdef TWIDDLE_CONJ_EN
        run_frame(1'b1);
`endif

        // Mixed traffic.
        for (int i = 0; i < 120; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-frame.
        step(1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b0);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
